// File: rtl/cnn_seq_pkg.sv
// ---------------------------------------------------------------------------
// cnn_seq_pkg
// Shared definitions for the CNN layer sequencer and anything that talks to
// it: the sequencer state encoding and the stage-index width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package cnn_seq_pkg;

    // Sequencer state encoding.
    localparam int         STATE_W   = 3;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    // Width of a stage index; a single-stage sequencer still gets one bit.
    function automatic int stg_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_stage_timer.sv
// ---------------------------------------------------------------------------
// cnn_stage_timer
// Per-stage cycle timer: loads 1 on launch, then counts up one per cycle and
// sticks at all-ones. 'expired' flags the cycle in which the count equals
// TIMEOUT (never asserted when TIMEOUT is 0).
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-low reset
//   load     in   load the count with 1
//   inc      in   advance the count (saturating)
//   count    out  current count, CNT_W bits
//   expired  out  count == TIMEOUT and the watchdog is enabled
// ---------------------------------------------------------------------------
module cnn_stage_timer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Compare at 64 bits so a TIMEOUT wider than the counter simply never fires.
    localparam logic [63:0]      LIMIT   = 64'(TIMEOUT);
    localparam bit               WD_EN   = (TIMEOUT != 0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = WD_EN && (64'(count) == LIMIT);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_layer_sequencer
// Launches up to NUM_STAGES compute stages in index order, one at a time,
// skipping masked stages. Each stage gets a single-cycle start pulse; the
// sequencer waits for that stage's done, records how many cycles it took,
// and moves on. A watchdog flags a stage that never finishes.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-low reset
//   run          in   start a sequence (honoured in IDLE, DONE, ERROR)
//   abort        in   cancel the running sequence, back to IDLE
//   skip_mask    in   bit i=1 skips stage i, captured with run
//   stage_done   in   completion from each engine
//   stage_start  out  one-hot single-cycle launch pulse
//   stage_sel    out  index of the active (or last active) stage
//   busy         out  a stage is being launched or awaited
//   seq_done     out  single-cycle pulse after the last stage completes
//   err          out  sticky watchdog error
//   err_stage    out  stage that timed out
//   rd_idx       in   readback stage index
//   rd_cycles    out  recorded cycles for rd_idx, 0 when out of range
// ---------------------------------------------------------------------------
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter  int NUM_STAGES = 4,
    parameter  int CNT_W      = 32,
    parameter  int TIMEOUT    = 1_000_000,
    localparam int STG_W      = stg_width(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] skip_mask,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [STG_W-1:0]      stage_sel,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  err,
    output logic [STG_W-1:0]      err_stage,
    input  logic [STG_W-1:0]      rd_idx,
    output logic [CNT_W-1:0]      rd_cycles
);

    logic [STATE_W-1:0]    state;
    logic [STG_W-1:0]      sel;
    logic [NUM_STAGES-1:0] mask;
    logic [CNT_W-1:0]      counts [NUM_STAGES];

    logic                  tmr_load;
    logic                  tmr_inc;
    logic                  tmr_expired;
    logic [CNT_W-1:0]      tmr_count;

    logic [STG_W:0]        first_hit;
    logic [STG_W:0]        next_hit;

    // Lowest unmasked index >= n; MSB of the result is the "found" flag.
    function automatic logic [STG_W:0] next_unmasked(input logic [NUM_STAGES-1:0] m,
                                                     input int n);
        logic [STG_W:0] res;
        res = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if ((i >= n) && !m[i]) begin
                res = {1'b1, STG_W'(i)};
            end
        end
        return res;
    endfunction

    // Recorded count is timer+1 (the done cycle itself), held at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign first_hit = next_unmasked(skip_mask, 0);
    assign next_hit  = next_unmasked(mask, int'(sel) + 1);

    assign tmr_load = (state == ST_LAUNCH);
    assign tmr_inc  = (state == ST_WAIT);

    cnn_stage_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .inc     (tmr_inc),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            sel       <= '0;
            mask      <= '0;
            err       <= 1'b0;
            err_stage <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                counts[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (run) begin
                        mask <= skip_mask;
                        err  <= 1'b0;
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            counts[i] <= '0;
                        end
                        if (first_hit[STG_W]) begin
                            sel   <= first_hit[STG_W-1:0];
                            state <= ST_LAUNCH;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else if (state == ST_DONE) begin
                        state <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    state <= abort ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    // abort beats done, done beats the watchdog
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (stage_done[sel]) begin
                        counts[sel] <= sat_inc(tmr_count);
                        if (next_hit[STG_W]) begin
                            sel   <= next_hit[STG_W-1:0];
                            state <= ST_LAUNCH;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else if (tmr_expired) begin
                        err       <= 1'b1;
                        err_stage <= sel;
                        state     <= ST_ERROR;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stage_start = '0;
        if (state == ST_LAUNCH) begin
            stage_start[sel] = 1'b1;
        end
    end

    assign stage_sel = sel;
    assign busy      = (state == ST_LAUNCH) || (state == ST_WAIT);
    assign seq_done  = (state == ST_DONE);
    assign rd_cycles = (int'(rd_idx) < NUM_STAGES) ? counts[rd_idx] : '0;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cnn_layer_sequencer
// Directed bench for cnn_layer_sequencer (4 stages, watchdog limit 50).
// Engine models answer each start pulse with a done pulse after a programmed
// delay. For each run a timeline of expected outputs is derived from the
// stage delays and mask, and a compare process checks every cycle against it;
// recorded counts are read back afterwards and a few are pinned to literals.
// ---------------------------------------------------------------------------
module tb_cnn_layer_sequencer;
    import cnn_seq_pkg::*;

    localparam int N    = 4;
    localparam int CW   = 32;
    localparam int TO   = 50;
    localparam int SW   = stg_width(N);
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  skip_mask = '0;
    logic [N-1:0]  stage_done = '0;
    logic [N-1:0]  stage_start;
    logic [SW-1:0] stage_sel;
    logic          busy;
    logic          seq_done;
    logic          err;
    logic [SW-1:0] err_stage;
    logic [SW-1:0] rd_idx = '0;
    logic [CW-1:0] rd_cycles;

    cnn_layer_sequencer #(
        .NUM_STAGES (N),
        .CNT_W      (CW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .abort       (abort),
        .skip_mask   (skip_mask),
        .stage_done  (stage_done),
        .stage_start (stage_start),
        .stage_sel   (stage_sel),
        .busy        (busy),
        .seq_done    (seq_done),
        .err         (err),
        .err_stage   (err_stage),
        .rd_idx      (rd_idx),
        .rd_cycles   (rd_cycles)
    );

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    bit         chk_on = 1'b0;
    int         dly [N];
    int         due [N];
    logic [N-1:0] spur = '0;

    // Expected timeline, indexed by absolute cycle number.
    logic [N-1:0] e_start [MAXC];
    bit           e_busy  [MAXC];
    bit           e_done  [MAXC];
    bit           e_err   [MAXC];
    int           e_sel   [MAXC];
    int           e_cnt   [N];
    int           e_dcyc  [N];
    int           e_err_stage = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine models: done pulses dly[i] cycles after the start cycle (never if dly<=0).
    initial for (int i = 0; i < N; i++) due[i] = -1;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (stage_start[i]) due[i] = (dly[i] > 0) ? cyc + dly[i] : -1;
        end
    end

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++) stage_done[i] = (due[i] == cyc) | spur[i];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("stage_start", 64'(stage_start), 64'(e_start[cyc]));
            chk("busy", 64'(busy), 64'(e_busy[cyc]));
            chk("seq_done", 64'(seq_done), 64'(e_done[cyc]));
            chk("err", 64'(err), 64'(e_err[cyc]));
            if (e_busy[cyc]) chk("stage_sel", 64'(stage_sel), 64'(e_sel[cyc]));
        end
    end

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mark(input int a, input int b, input int s);
        for (int c = a; c <= b && c < MAXC; c++) begin
            e_busy[c] = 1'b1;
            e_sel[c]  = s;
        end
    endtask

    // Run sampled at the end of cycle r: derive outputs for cycles r+1..wend.
    task automatic plan(input int r, input logic [N-1:0] m, input int wend);
        int t;
        bit fin;
        for (int c = r + 1; c <= wend; c++) begin
            e_start[c] = '0; e_busy[c] = 1'b0; e_done[c] = 1'b0; e_err[c] = 1'b0; e_sel[c] = 0;
        end
        for (int i = 0; i < N; i++) begin
            e_cnt[i]  = 0;
            e_dcyc[i] = -1;
        end
        t   = r + 1;
        fin = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (!m[i] && fin) begin
                e_start[t][i] = 1'b1;
                if (dly[i] <= 0 || dly[i] > TO) begin
                    mark(t, t + TO, i);
                    for (int c = t + TO + 1; c <= wend; c++) e_err[c] = 1'b1;
                    e_err_stage = i;
                    fin = 1'b0;
                end else begin
                    mark(t, t + dly[i], i);
                    e_cnt[i]  = dly[i] + 1;
                    e_dcyc[i] = t + dly[i];
                    t = t + dly[i] + 1;
                end
            end
        end
        if (fin) e_done[t] = 1'b1;
    endtask

    // Sequence cancelled (abort or reset) so that cycle c is idle.
    task automatic cut(input int c, input int wend, input bit by_rst);
        for (int k = c; k <= wend; k++) begin
            e_start[k] = '0; e_busy[k] = 1'b0; e_done[k] = 1'b0; e_err[k] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (by_rst || e_dcyc[i] >= c - 1) e_cnt[i] = 0;
        end
        if (by_rst) e_err_stage = 0;
    endtask

    task automatic check_rd();
        for (int i = 0; i < N; i++) begin
            rd_idx = SW'(i);
            #1;
            chk("rd_cycles", 64'(rd_cycles), 64'(e_cnt[i]));
        end
        chk("err_stage", 64'(err_stage), 64'(e_err_stage));
    endtask

    task automatic lit(input string nm, input int idx, input int val);
        rd_idx = SW'(idx);
        #1;
        chk(nm, 64'(rd_cycles), 64'(val));
    endtask

    // ab/rs/sp: cycle (relative to the run cycle) of abort / reset / spurious done[3]; 0 = none.
    task automatic scenario(input logic [N-1:0] m, input int len, input int ab,
                            input int rs, input int sp);
        int r;
        repeat (60) wait_cycle();
        wait_cycle();
        skip_mask = m;
        run = 1'b1;
        r = cyc;
        plan(r, m, r + len);
        if (ab > 0) cut(r + ab + 1, r + len, 1'b0);
        if (rs > 0) cut(r + rs + 1, r + len, 1'b1);
        wait_cycle();
        run = 1'b0;
        chk_on = 1'b1;
        while (cyc < r + len) begin
            wait_cycle();
            spur  = (sp > 0 && cyc == r + sp) ? 4'b1000 : 4'b0000;
            abort = (ab > 0 && cyc == r + ab);
            rst   = !(rs > 0 && cyc == r + rs);
        end
        chk_on = 1'b0;
        spur = '0; abort = 1'b0; rst = 1'b1;
        check_rd();
    endtask

    initial begin
        for (int i = 0; i < N; i++) dly[i] = 1;

        // Reset state
        repeat (3) wait_cycle();
        chk("rst_stage_start", 64'(stage_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_seq_done", 64'(seq_done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_stage_sel", 64'(stage_sel), 64'd0);
        chk("rst_err_stage", 64'(err_stage), 64'd0);
        rst = 1'b1;
        for (int i = 0; i < N; i++) lit("rst_rd_cycles", i, 0);

        // Full run
        dly = '{10, 20, 5, 3};
        scenario(4'b0000, 60, 0, 0, 0);
        lit("full_rd0", 0, 11);
        lit("full_rd1", 1, 21);
        lit("full_rd2", 2, 6);
        lit("full_rd3", 3, 4);

        // Skip stages 0 and 2
        scenario(4'b0101, 60, 0, 0, 0);
        lit("skip_rd0", 0, 0);
        lit("skip_rd1", 1, 21);
        lit("skip_rd2", 2, 0);

        // Everything masked
        scenario(4'b1111, 10, 0, 0, 0);

        // Watchdog on stage 2
        dly = '{4, 6, 0, 3};
        scenario(4'b0000, 80, 0, 0, 0);
        chk("wd_err_stage", 64'(err_stage), 64'd2);
        chk("wd_err", 64'(err), 64'd1);
        chk("wd_busy", 64'(busy), 64'd0);

        // Restart from ERROR
        dly = '{2, 2, 2, 2};
        scenario(4'b0000, 30, 0, 0, 0);
        lit("restart_rd0", 0, 3);

        // Done exactly at the watchdog limit
        dly = '{50, 1, 1, 1};
        scenario(4'b0000, 70, 0, 0, 0);
        lit("limit_rd0", 0, 51);

        // Abort mid-WAIT on stage 1, spurious done[3] while stage 0 runs
        dly = '{3, 30, 1, 1};
        scenario(4'b0000, 40, 10, 0, 2);
        lit("abort_rd0", 0, 4);
        lit("abort_rd1", 1, 0);

        // Reset mid-stage, then stays idle
        dly = '{20, 1, 1, 1};
        scenario(4'b0000, 40, 0, 5, 0);
        chk("rst_mid_stage_sel", 64'(stage_sel), 64'd0);
        chk("rst_mid_err_stage", 64'(err_stage), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
